// File: rtl/arbiter_puf_pkg.sv
// arbiter_puf_pkg: shared state encoding, LFSR tap masks and clog2 helper for the arbiter PUF engine
package arbiter_puf_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, LAUNCH, SETTLE, SAMPLE, RELAX, NEXT, DONE} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic logic [31:0] lfsr_mask(input int n);
    case (n)
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0E08;
      13:      return 32'h0000_1C80;
      14:      return 32'h0000_3802;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_B400;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0007_2000;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      default: return 32'h8020_0003;
    endcase
  endfunction
endpackage

// File: rtl/puf_core.sv
// puf_core: symmetric C_LENGTH-stage switch-box delay chain racing one launch edge into an arbiter flop
module puf_core #(
  parameter int C_LENGTH = 16
) (
  input  logic                launch,
  input  logic [C_LENGTH-1:0] challenge,
  output logic                raw
);
  logic t_end, b_end;
  for (genvar i = 0; i < C_LENGTH; i++) begin : g_st
    logic t_in, b_in, t, b;
    if (i == 0) begin : g_first
      assign t_in = launch;
      assign b_in = launch;
    end else begin : g_rest
      assign t_in = g_st[i-1].t;
      assign b_in = g_st[i-1].b;
    end
    assign t = challenge[i] ? b_in : t_in;
    assign b = challenge[i] ? t_in : b_in;
  end
  assign t_end = g_st[C_LENGTH-1].t;
  assign b_end = g_st[C_LENGTH-1].b;
  // arbiter: records 1 when the top path arrived before the bottom path's edge
  always_ff @(posedge b_end) raw <= t_end;
endmodule

// File: rtl/arbiter_puf_engine.sv
// arbiter_puf_engine: LFSR challenge sequencer with majority-voted PUF response; ARBITER_PUF_STABILITY_EN adds per-bit unstable flags
module arbiter_puf_engine
  import arbiter_puf_pkg::*;
#(
  parameter int C_LENGTH   = 16,
  parameter int RESP_WIDTH = 8,
  parameter int NUM_EVAL   = 5,
  parameter int SETTLE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [C_LENGTH-1:0]   seed,
  output logic                  busy,
  output logic                  done,
  output logic [RESP_WIDTH-1:0] response
`ifdef ARBITER_PUF_STABILITY_EN
  ,
  output logic [RESP_WIDTH-1:0] unstable
`endif
);
  localparam int EW = clog2(NUM_EVAL + 1);
  localparam int BW = clog2(RESP_WIDTH + 1);
  localparam int TW = clog2(SETTLE_CYC + 1);
  localparam logic [C_LENGTH-1:0] MASK = C_LENGTH'(lfsr_mask(C_LENGTH));
  state_t                state;
  logic [C_LENGTH-1:0]   lfsr, lfsr_nxt, challenge;
  logic                  launch, raw_bit, vbit, unan, last_bit;
  logic [1:0]            sync;
  logic [EW-1:0]         cnt, eval_idx;
  logic [BW-1:0]         bit_idx;
  logic [TW-1:0]         tmr;
  logic [RESP_WIDTH-1:0] shreg;
  assign challenge = lfsr;
  assign lfsr_nxt  = (lfsr >> 1) ^ (lfsr[0] ? MASK : '0);
  assign vbit      = cnt > EW'(NUM_EVAL / 2);
  assign unan      = (cnt == '0) || (cnt == EW'(NUM_EVAL));
  assign last_bit  = bit_idx == BW'(RESP_WIDTH - 1);
  (* dont_touch = "true", keep_hierarchy = "yes" *)
  puf_core #(.C_LENGTH(C_LENGTH)) u_core (
    .launch    (launch),
    .challenge (challenge),
    .raw       (raw_bit)
  );
  // two-flop synchroniser bringing the arbiter decision into the clk domain
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= '0;
    else sync <= {sync[0], raw_bit};
  // sequencer: load seed, launch/settle/sample/relax NUM_EVAL times per bit, vote, advance LFSR
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      lfsr     <= C_LENGTH'(1);
      launch   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      response <= '0;
      shreg    <= '0;
      cnt      <= '0;
      eval_idx <= '0;
      bit_idx  <= '0;
      tmr      <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          busy  <= 1'b1;
          lfsr  <= (seed == '0) ? C_LENGTH'(1) : seed;
        end
        LOAD: begin
          cnt      <= '0;
          eval_idx <= '0;
          bit_idx  <= '0;
          tmr      <= '0;
          state    <= LAUNCH;
        end
        LAUNCH: begin
          launch <= 1'b1;
          tmr    <= '0;
          state  <= SETTLE;
        end
        SETTLE: begin
          tmr   <= (tmr == TW'(SETTLE_CYC - 1)) ? '0 : tmr + 1'b1;
          state <= (tmr == TW'(SETTLE_CYC - 1)) ? SAMPLE : SETTLE;
        end
        SAMPLE: begin
          cnt   <= cnt + EW'(sync[1]);
          state <= RELAX;
        end
        RELAX: begin
          launch <= 1'b0;
          tmr    <= (tmr == TW'(SETTLE_CYC - 1)) ? '0 : tmr + 1'b1;
          if (tmr == TW'(SETTLE_CYC - 1)) begin
            eval_idx <= (eval_idx < EW'(NUM_EVAL - 1)) ? eval_idx + 1'b1 : eval_idx;
            state    <= (eval_idx < EW'(NUM_EVAL - 1)) ? LAUNCH : NEXT;
          end
        end
        NEXT: begin
          shreg    <= RESP_WIDTH'({shreg, vbit});
          lfsr     <= lfsr_nxt;
          cnt      <= '0;
          eval_idx <= '0;
          bit_idx  <= last_bit ? bit_idx : bit_idx + 1'b1;
          state    <= last_bit ? DONE : LAUNCH;
          done     <= last_bit;
          if (last_bit) response <= RESP_WIDTH'({shreg, vbit});
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef ARBITER_PUF_STABILITY_EN
  logic [RESP_WIDTH-1:0] ushreg;
  // non-unanimous vote flags, shifted in step with the response bits
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ushreg   <= '0;
      unstable <= '0;
    end else if (state == NEXT) begin
      ushreg <= RESP_WIDTH'({ushreg, ~unan});
      if (last_bit) unstable <= RESP_WIDTH'({ushreg, ~unan});
    end
`else
  logic unused_unan;
  assign unused_unan = unan;
`endif
endmodule
